// File: rtl/conv_fmap_collector_pkg.sv
// conv_fmap_collector_pkg: sizes, bank states and tile-position helpers for the fmap collector.
package conv_fmap_collector_pkg;
  localparam int DATA_W = 8;
  localparam int TILE = 4;
  localparam int TPR = 3;
  localparam int NPOS = 9;
  localparam int CNT_W = 5;
  localparam int POS_W = 4;
  localparam int MAP_W = TILE * TPR;
  localparam int TILE_BITS = TILE * TILE * DATA_W;
  localparam int MAP_BITS = MAP_W * MAP_W * DATA_W;
  localparam int WGT_BITS = 9 * DATA_W;
  typedef enum logic [1:0] {
    BK_EMPTY   = 2'd0,
    BK_FILLING = 2'd1,
    BK_FULL    = 2'd2
  } bank_st_e;
  function automatic logic [1:0] pos_row(input logic [POS_W-1:0] pos);
    return pos >= 4'd6 ? 2'd2 : pos >= 4'd3 ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [1:0] pos_col(input logic [POS_W-1:0] pos);
    return 2'(pos - 4'(3 * pos_row(pos)));
  endfunction
endpackage

// File: rtl/conv_fmap_collector_bank.sv
// conv_fmap_collector_bank: one ping-pong bank holding a 12x12 map, tile mask, channel and weight.
module conv_fmap_collector_bank
  import conv_fmap_collector_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  wr_en,
  input  logic                  restart,
  input  logic                  clr,
  input  logic [POS_W-1:0]      pos,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic [0:TILE_BITS-1]  data_in,
  input  logic [0:WGT_BITS-1]   wgt_in,
  output bank_st_e              st,
  output logic [CNT_W-1:0]      cnt,
  output logic [0:MAP_BITS-1]   data,
  output logic [0:WGT_BITS-1]   wgt,
  output logic                  done
);
  bank_st_e st_q, st_d;
  logic [NPOS-1:0] mask_q, mask_d, base_mask, new_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:MAP_BITS-1] data_q, data_d;
  logic [0:WGT_BITS-1] wgt_q, wgt_d;
  logic [3:0] row0, col0;
  logic fresh;
  assign row0 = {pos_row(pos), 2'b00};
  assign col0 = {pos_col(pos), 2'b00};
  // A new channel on a filling bank throws away the partial mask and starts over.
  assign fresh = st_q == BK_EMPTY || restart;
  always_comb begin
    base_mask = fresh ? '0 : mask_q;
    new_mask = base_mask | (NPOS'(1) << pos);
    done = wr_en && &new_mask;
    mask_d = wr_en ? new_mask : clr ? '0 : mask_q;
    st_d = clr ? BK_EMPTY : wr_en ? (done ? BK_FULL : BK_FILLING) : st_q;
    cnt_d = (wr_en && fresh) ? cnt_in : cnt_q;
    wgt_d = wr_en ? wgt_in : wgt_q;
    data_d = data_q;
    if (wr_en)
      for (int r = 0; r < TILE; r++)
        for (int c = 0; c < TILE; c++)
          data_d[((32'(row0) + r) * MAP_W + 32'(col0) + c) * DATA_W +: DATA_W] =
            data_in[(r * TILE + c) * DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_q <= BK_EMPTY;
      mask_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      wgt_q <= '0;
    end else begin
      st_q <= st_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      wgt_q <= wgt_d;
    end
  end
  assign st = st_q;
  assign cnt = cnt_q;
  assign data = data_q;
  assign wgt = wgt_q;
endmodule

// File: rtl/conv_fmap_collector.sv
// conv_fmap_collector: gathers 4x4 conv tiles into 12x12 per-channel maps in a ping-pong
// buffer and hands finished maps to the depthwise stage over valid/ready.
module conv_fmap_collector
  import conv_fmap_collector_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  en,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic [POS_W-1:0]      pos_in,
  input  logic [0:TILE_BITS-1]  in_data,
  input  logic [0:WGT_BITS-1]   wgt_in,
  output logic                  fmap_valid,
  input  logic                  fmap_ready,
  output logic [CNT_W-1:0]      fmap_cnt,
  output logic [0:MAP_BITS-1]   fmap_data,
  output logic [0:WGT_BITS-1]   fmap_wgt,
  output logic                  buf_full,
  output logic                  err
);
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, err_q, err_d;
  logic pos_ok, wr_full, accept, restart, fire;
  bank_st_e bk_st [2];
  logic [CNT_W-1:0] bk_cnt [2];
  logic [0:MAP_BITS-1] bk_data [2];
  logic [0:WGT_BITS-1] bk_wgt [2];
  logic bk_done [2];
  assign pos_ok = pos_in <= POS_W'(NPOS - 1);
  assign wr_full = bk_st[wr_bank_q] == BK_FULL;
  assign accept = en && pos_ok && !wr_full;
  assign restart = bk_st[wr_bank_q] == BK_FILLING && cnt_in != bk_cnt[wr_bank_q];
  assign fmap_valid = bk_st[rd_bank_q] == BK_FULL;
  assign fire = fmap_valid && fmap_ready;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    conv_fmap_collector_bank u_bank (
      .clk     (clk),
      .rst_b   (rst_b),
      .wr_en   (accept && wr_bank_q == 1'(b)),
      .restart (restart),
      .clr     (fire && rd_bank_q == 1'(b)),
      .pos     (pos_in),
      .cnt_in  (cnt_in),
      .data_in (in_data),
      .wgt_in  (wgt_in),
      .st      (bk_st[b]),
      .cnt     (bk_cnt[b]),
      .data    (bk_data[b]),
      .wgt     (bk_wgt[b]),
      .done    (bk_done[b])
    );
  end
  always_comb begin
    wr_bank_d = wr_bank_q ^ (bk_done[0] | bk_done[1]);
    rd_bank_d = rd_bank_q ^ fire;
    err_d = err_q | (en && (!pos_ok || wr_full)) | (accept && restart);
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_q <= err_d;
    end
  end
  assign fmap_cnt = fmap_valid ? bk_cnt[rd_bank_q] : '0;
  assign fmap_data = fmap_valid ? bk_data[rd_bank_q] : '0;
  assign fmap_wgt = fmap_valid ? bk_wgt[rd_bank_q] : '0;
  assign buf_full = wr_full;
  assign err = err_q;
endmodule

// File: tb/tb_conv_fmap_collector.sv
// tb_conv_fmap_collector: directed tile sequences checked every cycle against a queue-of-maps model.
module tb_conv_fmap_collector;
  logic clk = 1'b0, rst_b = 1'b0, en = 1'b0, fmap_ready = 1'b0;
  logic [4:0] cnt_in = '0;
  logic [3:0] pos_in = '0;
  logic [0:127] in_data = '0;
  logic [0:71] wgt_in = '0;
  logic fmap_valid, buf_full, err;
  logic [4:0] fmap_cnt;
  logic [0:1151] fmap_data;
  logic [0:71] fmap_wgt;
  always #5 clk = ~clk;
  conv_fmap_collector dut (
    .clk(clk), .rst_b(rst_b), .en(en), .cnt_in(cnt_in), .pos_in(pos_in), .in_data(in_data),
    .wgt_in(wgt_in), .fmap_valid(fmap_valid), .fmap_ready(fmap_ready), .fmap_cnt(fmap_cnt),
    .fmap_data(fmap_data), .fmap_wgt(fmap_wgt), .buf_full(buf_full), .err(err)
  );
  typedef struct packed {
    logic [4:0] cnt;
    logic [0:71] w;
    logic [0:1151] d;
  } map_t;
  map_t mq[$];
  logic [8:0] fmask;
  logic [4:0] fcnt;
  logic [0:71] fwgt;
  logic [0:1151] fdata;
  logic merr;
  int total = 0, bad = 0, pops = 0;
  function automatic logic [0:127] tile(int pos, int base);
    logic [0:127] t;
    for (int i = 0; i < 16; i++) t[i*8 +: 8] = 8'(base + pos * 16 + i);
    return t;
  endfunction
  function automatic logic [0:71] wts(int seed);
    logic [0:71] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(seed + k + 1);
    return w;
  endfunction
  task automatic model_reset();
    mq.delete();
    fmask = '0;
    fcnt = '0;
    fwgt = '0;
    fdata = '0;
    merr = 1'b0;
  endtask
  // Completed maps wait in a FIFO; both banks are occupied once two maps are waiting.
  task automatic model_step();
    bit full, pop;
    int p;
    full = mq.size() == 2;
    pop = mq.size() > 0 && fmap_ready;
    p = int'(pos_in);
    if (en) begin
      if (p > 8 || full) merr = 1'b1;
      else begin
        if (fmask != 0 && cnt_in != fcnt) begin
          merr = 1'b1;
          fmask = '0;
        end
        if (fmask == 0) fcnt = cnt_in;
        for (int i = 0; i < 16; i++)
          fdata[(((p / 3) * 4 + i / 4) * 12 + (p % 3) * 4 + i % 4) * 8 +: 8] = in_data[i*8 +: 8];
        fmask[p] = 1'b1;
        fwgt = wgt_in;
        if (fmask == 9'h1FF) begin
          mq.push_back('{cnt: fcnt, w: fwgt, d: fdata});
          fmask = '0;
        end
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      pops++;
    end
  endtask
  task automatic cmp(string nm, logic [71:0] got, logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic cmp_map(logic [0:1151] got, logic [0:1151] exp);
    total++;
    if (got !== exp) begin
      bad++;
      for (int i = 0; i < 144; i++)
        if (got[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL fmap_data byte %0d got=%02h exp=%02h at %0t", i, got[i*8 +: 8], exp[i*8 +: 8], $time);
          break;
        end
    end
  endtask
  task automatic check_all();
    map_t f;
    f = mq.size() > 0 ? mq[0] : '0;
    cmp("fmap_valid", 72'(fmap_valid), 72'(mq.size() > 0));
    cmp("fmap_cnt", 72'(fmap_cnt), 72'(f.cnt));
    cmp("fmap_wgt", 72'(fmap_wgt), 72'(f.w));
    cmp_map(fmap_data, f.d);
    cmp("buf_full", 72'(buf_full), 72'(mq.size() == 2));
    cmp("err", 72'(err), 72'(merr));
  endtask
  task automatic tick(bit e, int c, int p, int base, int seed, bit rdy);
    en = e;
    cnt_in = 5'(c);
    pos_in = 4'(p);
    in_data = tile(p, base);
    wgt_in = wts(seed);
    fmap_ready = rdy;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask
  task automatic fill(int c, int first, int last, int base, int seed, bit rdy);
    for (int p = first; p <= last; p++) tick(1'b1, c, p, base, seed, rdy);
  endtask
  task automatic do_reset();
    #2 rst_b = 1'b0;
    model_reset();
    #1 check_all();
    cmp("rst_valid", 72'(fmap_valid), 72'd0);
    cmp("rst_full", 72'(buf_full), 72'd0);
    cmp("rst_err", 72'(err), 72'd0);
    cmp("rst_cnt", 72'(fmap_cnt), 72'd0);
    @(negedge clk);
    rst_b = 1'b1;
  endtask
  int order[10] = '{8, 0, 4, 3, 1, 2, 3, 5, 6, 7};
  int pops0;
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    cmp("init_valid", 72'(fmap_valid), 72'd0);
    rst_b = 1'b1;
    // basic fill, channel 5
    fill(5, 0, 7, 0, 0, 1'b0);
    cmp("t1_not_yet", 72'(fmap_valid), 72'd0);
    tick(1'b1, 5, 8, 0, 0, 1'b0);
    cmp("t1_valid", 72'(fmap_valid), 72'd1);
    cmp("t1_cnt", 72'(fmap_cnt), 72'd5);
    cmp("t1_r0c0", 72'(fmap_data[0 +: 8]), 72'h00);
    cmp("t1_r11c11", 72'(fmap_data[143*8 +: 8]), 72'h8F);
    cmp("t1_r0c4", 72'(fmap_data[4*8 +: 8]), 72'h10);
    cmp("t1_w0", 72'(fmap_wgt[0 +: 8]), 72'h01);
    cmp("t1_w8", 72'(fmap_wgt[64 +: 8]), 72'h09);
    tick(1'b0, 0, 0, 0, 0, 1'b1);
    cmp("t1_popped", 72'(fmap_valid), 72'd0);
    // shuffled order with a duplicate pos 3 carrying newer data
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1, order[i], (i == 6) ? 8'h40 : 0, 16, 1'b0);
      if (i == 8) cmp("t2_not_yet", 72'(fmap_valid), 72'd0);
    end
    cmp("t2_valid", 72'(fmap_valid), 72'd1);
    cmp("t2_dup_r4c0", 72'(fmap_data[48*8 +: 8]), 72'h70);
    cmp("t2_err", 72'(err), 72'd0);
    tick(1'b0, 0, 0, 0, 0, 1'b1);
    // out-of-range position
    tick(1'b1, 1, 9, 0, 0, 1'b0);
    cmp("bad_pos_err", 72'(err), 72'd1);
    cmp("bad_pos_valid", 72'(fmap_valid), 72'd0);
    tick(1'b1, 1, 15, 0, 0, 1'b0);
    do_reset();
    // both banks full, drops
    fill(5, 0, 8, 0, 0, 1'b0);
    fill(6, 0, 8, 8'h80, 32, 1'b0);
    cmp("t3_full", 72'(buf_full), 72'd1);
    cmp("t3_err0", 72'(err), 72'd0);
    tick(1'b1, 7, 0, 0, 0, 1'b0);
    cmp("t3_drop_err", 72'(err), 72'd1);
    cmp("t3_cnt5", 72'(fmap_cnt), 72'd5);
    tick(1'b1, 7, 1, 0, 0, 1'b1);
    cmp("t3_cnt6", 72'(fmap_cnt), 72'd6);
    tick(1'b0, 0, 0, 0, 0, 1'b1);
    cmp("t3_empty", 72'(fmap_valid), 72'd0);
    do_reset();
    // channel switch mid-fill
    fill(2, 0, 4, 8'hA0, 0, 1'b0);
    fill(3, 0, 8, 8'h10, 48, 1'b0);
    cmp("t4_err", 72'(err), 72'd1);
    cmp("t4_cnt", 72'(fmap_cnt), 72'd3);
    cmp("t4_r0c0", 72'(fmap_data[0 +: 8]), 72'h10);
    cmp("t4_full", 72'(buf_full), 72'd0);
    tick(1'b0, 0, 0, 0, 0, 1'b1);
    cmp("t4_single", 72'(fmap_valid), 72'd0);
    // back-to-back with ready held high
    pops0 = pops;
    for (int c = 0; c < 4; c++) fill(c, 0, 8, c * 8, c, 1'b1);
    repeat (3) tick(1'b0, 0, 0, 0, 0, 1'b1);
    cmp("t5_pops", 72'(pops - pops0), 72'd4);
    // async reset with one bank full and the other mid-fill
    fill(1, 0, 8, 0, 0, 1'b0);
    fill(2, 0, 3, 0, 0, 1'b0);
    cmp("t6_pre_valid", 72'(fmap_valid), 72'd1);
    do_reset();
    fill(4, 0, 8, 8'h33, 64, 1'b0);
    cmp("t6_valid", 72'(fmap_valid), 72'd1);
    cmp("t6_cnt", 72'(fmap_cnt), 72'd4);
    cmp("t6_r0c0", 72'(fmap_data[0 +: 8]), 72'h33);
    tick(1'b0, 0, 0, 0, 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
